// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the TinyVGA receive-side frame monitor.
// Timing defaults describe standard 640x480 at one sample per pixel.
package vga_mon_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } mon_state_t;

    // TinyVGA Pmod bit positions on the 8-bit bus
    localparam int unsigned VGA_R1    = 0;
    localparam int unsigned VGA_G1    = 1;
    localparam int unsigned VGA_B1    = 2;
    localparam int unsigned VGA_VSYNC = 3;
    localparam int unsigned VGA_R0    = 4;
    localparam int unsigned VGA_G0    = 5;
    localparam int unsigned VGA_B0    = 6;
    localparam int unsigned VGA_HSYNC = 7;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_TOTAL  = 800;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_TOTAL  = 525;
    localparam bit          DEF_SYNC_POL = 1'b0;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16/CCITT-FALSE update by one byte, MSB first, no reflection.
module crc16_ccitt_byte
    import vga_mon_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_out[15] ^ data[3'(7 - i)]) begin
                crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc_out = {crc_out[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/vga_frame_monitor.sv
// Recovers pixel position from TinyVGA syncs, checks 640x480-style timing,
// reports lock and summarises each completed frame with a CRC-16.
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    input  logic        sample_en,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [5:0]  pix_rgb,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_crc,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count,
    output logic        locked
);

    localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SW    = 11'(H_SYNC);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SW_LO = 10'(V_SYNC - 1);
    localparam logic [9:0]  V_SW_HI = 10'(V_SYNC);

    mon_state_t  state;
    logic        hs_prev, vs_prev;
    logic [10:0] pos;
    logic [9:0]  line;
    logic        arm;
    logic        h_seen;
    logic        dirty;
    logic [15:0] crc_acc;

    logic        hs_now, vs_now;
    logic        hs_rise, hs_fall, vs_rise, vs_fall;
    logic        origin;
    logic [10:0] pos_nxt;
    logic [9:0]  line_nxt;
    logic        arm_nxt;
    logic        err_now;
    logic        frame_bad;
    logic        active;
    logic [5:0]  rgb_now;
    logic [15:0] crc_upd;

    assign hs_now = (vga_in[VGA_HSYNC] == SYNC_POL);
    assign vs_now = (vga_in[VGA_VSYNC] == SYNC_POL);
    assign rgb_now = {vga_in[VGA_R1], vga_in[VGA_R0], vga_in[VGA_G1],
                      vga_in[VGA_G0], vga_in[VGA_B1], vga_in[VGA_B0]};

    // pos_nxt/line_nxt are the coordinates of the sample being taken now;
    // pos/line hold those of the previous sample.
    always_comb begin
        hs_rise  = hs_now & ~hs_prev;
        hs_fall  = ~hs_now & hs_prev;
        vs_rise  = vs_now & ~vs_prev;
        vs_fall  = ~vs_now & vs_prev;
        origin   = hs_rise & (arm | vs_rise);
        arm_nxt  = origin ? 1'b0 : (arm | vs_rise);

        pos_nxt = pos;
        if (hs_rise) begin
            pos_nxt = '0;
        end else if (pos != '1) begin
            pos_nxt = pos + 11'd1;
        end

        line_nxt = line;
        if (origin) begin
            line_nxt = '0;
        end else if (hs_rise && line != '1) begin
            line_nxt = line + 10'd1;
        end

        err_now = (hs_rise & h_seen & (pos != H_LAST))
                | (hs_fall & (pos_nxt != H_SW))
                | (origin & (line != V_LAST))
                | (vs_fall & (line_nxt != V_SW_LO) & (line_nxt != V_SW_HI));
        // Errors seen on the origin sample close out the frame just ending.
        frame_bad = dirty | err_now;

        active = (pos_nxt >= H_START) && (pos_nxt < H_END)
              && (line_nxt >= V_START) && (line_nxt < V_END)
              && !arm_nxt && (state != ST_SEARCH);
    end

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_acc),
        .data    ({2'b00, rgb_now}),
        .crc_out (crc_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            pos       <= '0;
            line      <= '0;
            arm       <= 1'b0;
            h_seen    <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (sample_en) begin
                hs_prev <= hs_now;
                vs_prev <= vs_now;
                pos     <= pos_nxt;
                line    <= line_nxt;
                arm     <= arm_nxt;
                if (hs_rise) begin
                    h_seen <= 1'b1;
                end
                if (active) begin
                    pix_valid <= 1'b1;
                    pix_x     <= 10'(pos_nxt - H_START);
                    pix_y     <= line_nxt - V_START;
                    pix_rgb   <= rgb_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SEARCH;
            locked      <= 1'b0;
            dirty       <= 1'b0;
            crc_acc     <= CRC16_INIT;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_crc   <= '0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (sample_en) begin
                if (origin) begin
                    dirty   <= 1'b0;
                    crc_acc <= CRC16_INIT;
                    unique case (state)
                        ST_SEARCH: begin
                            state  <= ST_ACQUIRE;
                            locked <= 1'b0;
                        end
                        ST_ACQUIRE, ST_LOCKED: begin
                            state  <= frame_bad ? ST_ACQUIRE : ST_LOCKED;
                            locked <= !frame_bad;
                        end
                        default: begin
                            state  <= ST_SEARCH;
                            locked <= 1'b0;
                        end
                    endcase
                    if (state != ST_SEARCH) begin
                        frame_done  <= 1'b1;
                        frame_ok    <= !frame_bad;
                        frame_crc   <= crc_acc;
                        frame_count <= frame_count + 16'd1;
                        if (frame_bad && err_count != '1) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end else begin
                    dirty <= frame_bad;
                    if (active) begin
                        crc_acc <= crc_upd;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench: a scaled-down timing instance driven frame by frame from a
// table, plus a 1x1-pixel instance driven line by line for known CRC values.
module tb_vga_frame_monitor;

    localparam int HA = 8, HB = 2, HS = 3, HT = 16;
    localparam int VA = 4, VB = 2, VS = 2, VT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  vga_m = 8'h88;
    logic [7:0]  vga_t = 8'h88;

    logic        m_pix_valid, t_pix_valid;
    logic [9:0]  m_pix_x, m_pix_y, t_pix_x, t_pix_y;
    logic [5:0]  m_pix_rgb, t_pix_rgb;
    logic        m_frame_done, m_frame_ok, t_frame_done, t_frame_ok;
    logic [15:0] m_frame_crc, m_frame_count, t_frame_crc, t_frame_count;
    logic [7:0]  m_err_count, t_err_count;
    logic        m_locked, t_locked;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_BP(HB), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_BP(VB), .V_SYNC(VS), .V_TOTAL(VT), .SYNC_POL(1'b0)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_m), .sample_en(sample_en),
        .pix_valid(m_pix_valid), .pix_x(m_pix_x), .pix_y(m_pix_y), .pix_rgb(m_pix_rgb),
        .frame_done(m_frame_done), .frame_ok(m_frame_ok), .frame_crc(m_frame_crc),
        .frame_count(m_frame_count), .err_count(m_err_count), .locked(m_locked)
    );

    vga_frame_monitor #(
        .H_ACTIVE(1), .H_BP(1), .H_SYNC(1), .H_TOTAL(4),
        .V_ACTIVE(1), .V_BP(1), .V_SYNC(1), .V_TOTAL(4), .SYNC_POL(1'b0)
    ) u_tiny (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_t), .sample_en(sample_en),
        .pix_valid(t_pix_valid), .pix_x(t_pix_x), .pix_y(t_pix_y), .pix_rgb(t_pix_rgb),
        .frame_done(t_frame_done), .frame_ok(t_frame_ok), .frame_crc(t_frame_crc),
        .frame_count(t_frame_count), .err_count(t_err_count), .locked(t_locked)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bus(input bit hs, input bit vs, input logic [5:0] rgb);
        return {~hs, rgb[0], rgb[2], rgb[4], ~vs, rgb[1], rgb[3], rgb[5]};
    endfunction

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [5:0] pat(input int x, input int y, input int mode);
        if (mode == 0) return 6'h3F;
        return 6'(x * 5 + y * 11 + 7);
    endfunction

    typedef struct {
        int long_line; int short_line; int mode; bit half; int rst_line; int nlines;
        bit e_done; bit e_ok; bit e_lock; int e_err; int e_cnt;
    } frame_t;

    typedef struct {
        bit vs; logic [5:0] rgb; bit e_valid; bit e_done; bit e_ok; logic [15:0] e_crc; bit e_lock;
    } tline_t;

    frame_t ftab[10];
    tline_t ttab[9];

    bit          seen;
    logic [15:0] crc_m;
    logic [9:0]  lx, ly;
    logic [5:0]  lrgb;

    task automatic model_reset();
        seen = 1'b0; crc_m = 16'hFFFF; lx = '0; ly = '0; lrgb = '0;
    endtask

    task automatic idle_clk();
        sample_en = 1'b0;
        @(posedge clk); #1;
        chk("idle_frame_done", m_frame_done, 0);
        chk("idle_pix_valid", m_pix_valid, 0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_pix", {m_pix_valid, m_pix_x, m_pix_y, m_pix_rgb}, 0);
        chk("midreset_frame", {m_frame_done, m_frame_ok, m_frame_crc, m_frame_count,
                               m_err_count, m_locked}, 0);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_frame(input frame_t f);
        int len, hsw, x, y;
        bit act;
        logic [5:0] rgb;
        for (int l = 0; l < f.nlines; l++) begin
            len = HT + ((l == f.long_line) ? 1 : 0);
            hsw = (l == f.short_line) ? HS - 1 : HS;
            for (int hc = 0; hc < len; hc++) begin
                x = hc - (HS + HB);
                y = l - (VS + VB);
                act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
                rgb = act ? pat(x, y, f.mode) : 6'(hc ^ 21);
                if (l == f.rst_line && hc == HT / 2) pulse_reset();
                vga_m = bus(hc < hsw, l < VS, rgb);
                sample_en = 1'b1;
                @(posedge clk); #1;
                if (l == 0 && hc == 0) begin
                    chk("frame_done", m_frame_done, f.e_done);
                    chk("frame_ok", m_frame_ok, f.e_ok);
                    chk("frame_crc", m_frame_crc, f.e_done ? crc_m : 16'h0000);
                    chk("frame_count", m_frame_count, f.e_cnt);
                    chk("err_count", m_err_count, f.e_err);
                    chk("locked", m_locked, f.e_lock);
                    seen = 1'b1;
                    crc_m = 16'hFFFF;
                end else begin
                    chk("no_frame_done", m_frame_done, 0);
                end
                chk("pix_valid", m_pix_valid, act && seen);
                if (act && seen) begin
                    lx = 10'(x); ly = 10'(y); lrgb = rgb;
                    crc_m = crc_ref(crc_m, {2'b00, rgb});
                    chk("pix_xy_rgb", {m_pix_x, m_pix_y, m_pix_rgb}, {lx, ly, lrgb});
                end else begin
                    chk("pix_hold", {m_pix_x, m_pix_y, m_pix_rgb}, {lx, ly, lrgb});
                end
                if (f.half) idle_clk();
            end
        end
    endtask

    initial begin
        //            long short mode half rst lines done ok lock err cnt
        ftab[0] = '{-1, -1, 0, 1'b0, -1, 10, 1'b0, 1'b0, 1'b0, 0, 0};
        ftab[1] = '{-1, -1, 0, 1'b0, -1, 10, 1'b1, 1'b1, 1'b1, 0, 1};
        ftab[2] = '{ 5, -1, 1, 1'b0, -1, 10, 1'b1, 1'b1, 1'b1, 0, 2};
        ftab[3] = '{-1, -1, 1, 1'b0, -1, 10, 1'b1, 1'b0, 1'b0, 1, 3};
        ftab[4] = '{-1,  3, 1, 1'b0, -1, 10, 1'b1, 1'b1, 1'b1, 1, 4};
        ftab[5] = '{-1, -1, 1, 1'b1, -1, 10, 1'b1, 1'b0, 1'b0, 2, 5};
        ftab[6] = '{-1, -1, 1, 1'b1, -1, 10, 1'b1, 1'b1, 1'b1, 2, 6};
        ftab[7] = '{-1, -1, 1, 1'b0,  6, 10, 1'b1, 1'b1, 1'b1, 2, 7};
        ftab[8] = '{-1, -1, 1, 1'b0, -1, 10, 1'b0, 1'b0, 1'b0, 0, 0};
        ftab[9] = '{-1, -1, 1, 1'b0, -1,  1, 1'b1, 1'b1, 1'b1, 0, 1};

        //           vs    rgb    valid done  ok    crc       lock
        ttab[0] = '{1'b1, 6'h2A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        ttab[1] = '{1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        ttab[2] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        ttab[3] = '{1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        ttab[4] = '{1'b1, 6'h2A, 1'b0, 1'b1, 1'b1, 16'hE1F0, 1'b1};
        ttab[5] = '{1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        ttab[6] = '{1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        ttab[7] = '{1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        ttab[8] = '{1'b1, 6'h2A, 1'b0, 1'b1, 1'b1, 16'h264C, 1'b1};

        model_reset();

        // Reset held while the buses toggle: everything stays cleared.
        for (int i = 0; i < 6; i++) begin
            vga_m = 8'($urandom);
            vga_t = 8'($urandom);
            sample_en = 1'b1;
            @(posedge clk); #1;
            chk("reset_pix", {m_pix_valid, m_pix_x, m_pix_y, m_pix_rgb}, 0);
            chk("reset_frame", {m_frame_done, m_frame_ok, m_frame_crc, m_frame_count,
                                m_err_count, m_locked}, 0);
            chk("reset_tiny", {t_frame_done, t_frame_crc, t_locked, t_pix_valid}, 0);
        end
        sample_en = 1'b0;
        vga_m = 8'h88;
        vga_t = 8'h88;
        #2 rst_n = 1'b1;

        // 1x1 active area, one pixel per frame.
        for (int i = 0; i < 9; i++) begin
            for (int hc = 0; hc < 4; hc++) begin
                vga_t = bus(hc == 0, ttab[i].vs, (hc == 2) ? ttab[i].rgb : 6'h2A);
                sample_en = 1'b1;
                @(posedge clk); #1;
                if (hc == 0) begin
                    chk("tiny_frame_done", t_frame_done, ttab[i].e_done);
                    if (ttab[i].e_done) begin
                        chk("tiny_frame_ok", t_frame_ok, ttab[i].e_ok);
                        chk("tiny_frame_crc", t_frame_crc, ttab[i].e_crc);
                    end
                    chk("tiny_locked", t_locked, ttab[i].e_lock);
                end
                if (hc == 2) begin
                    chk("tiny_pix_valid", t_pix_valid, ttab[i].e_valid);
                    if (ttab[i].e_valid)
                        chk("tiny_pix", {t_pix_x, t_pix_y, t_pix_rgb}, {20'h0, ttab[i].rgb});
                end
            end
        end
        vga_t = 8'h88;

        for (int i = 0; i < 10; i++) run_frame(ftab[i]);

        sample_en = 1'b0;
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
